// File: rtl/imem_loader_if.sv
// Byte-link and imem write-port bundle. The loader takes the slave side: it consumes
// the byte stream and drives the write port. The host/memory harness takes the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/len/words/checksum frames and writes LE words to imem; holds CPU until good.
// Word write 1 cycle after its last byte, status 1 cycle after checksum; rx_ready is 1 in every state after reset.
module imem_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN0 = 3'd1;
  localparam logic [2:0] LEN1 = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CHK  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        acc;
  logic [15:0] len_new;

  assign acc     = bus.rx_valid && rx_ready_q;
  assign len_new = {bus.rx_data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    rx_ready_d = 1'b1;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    words_d    = words_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        // Only SYNC (re)starts a frame; anything else is idle-line noise.
        if (acc && bus.rx_data == SYNC) begin
          state_d = LEN0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          bcnt_d  = 2'd0;
          words_d = '0;
          csum_d  = 8'd0;
        end
      end
      LEN0: begin
        if (acc) begin
          len_lo_d = bus.rx_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (acc) begin
          len_d = len_new;
          if (len_new == 16'd0 || {1'b0, len_new} > MAX_N) begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          asm_d  = {bus.rx_data, asm_q[31:8]};
          csum_d = csum_q + bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {bus.rx_data, asm_q[31:8]};
            waddr_d = words_q[ADDR_W-1:0];
            words_d = words_q + 1'b1;
            if (17'(words_q + 1'b1) == {1'b0, len_q}) begin
              state_d = CHK;
            end
          end
        end
      end
      CHK: begin
        if (acc) begin
          if (bus.rx_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      bcnt_q     <= 2'd0;
      asm_q      <= 32'd0;
      csum_q     <= 8'd0;
      words_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames with known outcomes, hand-written corner sequences,
// then random frames checked against a frame-level parsing model.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_hold, done, err;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_W(AW)) bus();

  imem_loader #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] obs_a[$];
  logic [31:0]   obs_d[$];
  logic [AW-1:0] exp_a[$];
  logic [31:0]   exp_d[$];

  bit m_done, m_err, m_hold;
  int m_words;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_a.push_back(bus.imem_waddr);
      obs_d.push_back(bus.imem_wdata);
    end
  end

  typedef struct {
    int           len;
    logic [159:0] bytes;
    int           gap;
    bit           e_done;
    bit           e_err;
    bit           e_hold;
    int           e_words;
    int           e_nwr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      failures++;
      $display("FAIL rx_ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_q(input logic [7:0] q[$], input int gap, input bit rnd);
    for (int k = 0; k < q.size(); k++)
      send_byte(q[k], rnd ? int'($urandom_range(0, gap)) : gap);
  endtask

  // Frame-level reference: scan for SYNC, read a whole frame, record writes and outcome.
  task automatic model_run(input logic [7:0] q[$]);
    int i, n, sum;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != 8'hA5) begin
        i++;
        continue;
      end
      m_done = 0; m_err = 0; m_hold = 1; m_words = 0;
      i++;
      if (i + 2 > q.size()) break;
      n = int'(q[i]) + 256 * int'(q[i+1]);
      i += 2;
      if (n == 0 || n > (1 << AW)) begin
        m_err = 1;
        continue;
      end
      if (i + 4 * n + 1 > q.size()) break;
      sum = 0;
      for (int k = 0; k < n; k++) begin
        exp_a.push_back(AW'(k));
        exp_d.push_back({q[i+3], q[i+2], q[i+1], q[i]});
        sum += int'(q[i]) + int'(q[i+1]) + int'(q[i+2]) + int'(q[i+3]);
        m_words++;
        i += 4;
      end
      if (q[i] == 8'(sum)) begin
        m_done = 1; m_hold = 0;
      end else begin
        m_err = 1;
      end
      i++;
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(obs_a.size()), 64'(exp_a.size()));
    for (int k = 0; k < obs_a.size() && k < exp_a.size(); k++) begin
      chk({tag, "_waddr"}, 64'(obs_a[k]), 64'(exp_a[k]));
      chk({tag, "_wdata"}, 64'(obs_d[k]), 64'(exp_d[k]));
    end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input bit h, input int w);
    chk({tag, "_done"}, 64'(done), 64'(d));
    chk({tag, "_err"}, 64'(err), 64'(e));
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(h));
    chk({tag, "_words"}, 64'(words_loaded), 64'(w));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'(0));
    chk({tag, "_imem_we"}, 64'(bus.imem_we), 64'(0));
    chk({tag, "_imem_waddr"}, 64'(bus.imem_waddr), 64'(0));
    chk({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'(0));
    check_status(tag, 1'b0, 1'b0, 1'b1, 0);
  endtask

  function automatic void model_reset();
    m_done = 0; m_err = 0; m_hold = 1; m_words = 0;
  endfunction

  localparam logic [159:0] GOOD = 160'hA5_02_00_B7_00_00_80_93_80_F0_FF_39;

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int n, sum;

    tbl[0] = '{12, GOOD, 0, 1'b1, 1'b0, 1'b0, 2, 2};
    tbl[1] = '{12, 160'hA5_02_00_B7_00_00_80_93_80_F0_FF_38, 0, 1'b0, 1'b1, 1'b1, 2, 2};
    tbl[2] = '{12, GOOD, 0, 1'b1, 1'b0, 1'b0, 2, 2};
    tbl[3] = '{15, 160'h00_FF_13_A5_02_00_B7_00_00_80_93_80_F0_FF_39, 3, 1'b1, 1'b0, 1'b0, 2, 2};
    tbl[4] = '{3, 160'hA5_00_00, 0, 1'b0, 1'b1, 1'b1, 0, 0};
    tbl[5] = '{3, 160'hA5_01_01, 0, 1'b0, 1'b1, 1'b1, 0, 0};
    tbl[6] = '{12, GOOD, 1, 1'b1, 1'b0, 1'b0, 2, 2};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_rx_ready", 64'(bus.rx_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("first_edge_rx_ready", 64'(bus.rx_ready), 64'(1));
    model_reset();

    for (int v = 0; v < 7; v++) begin
      q.delete();
      for (int k = 0; k < tbl[v].len; k++)
        q.push_back(tbl[v].bytes[8*(tbl[v].len-1-k) +: 8]);
      model_run(q);
      send_q(q, tbl[v].gap, 1'b0);
      repeat (3) @(negedge clk);
      check_status($sformatf("vec%0d", v), tbl[v].e_done, tbl[v].e_err, tbl[v].e_hold, tbl[v].e_words);
      chk($sformatf("vec%0d_nwr", v), 64'(obs_a.size()), 64'(tbl[v].e_nwr));
      if (v == 0 && obs_d.size() == 2) begin
        chk("vec0_word0", 64'(obs_d[0]), 64'h800000b7);
        chk("vec0_word1", 64'(obs_d[1]), 64'hfff08093);
      end
      check_writes($sformatf("vec%0d", v));
    end

    // Reload from DONE: CPU held during load, write latency and status latency of one cycle.
    q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    model_run(q);
    for (int k = 0; k < 4; k++) send_byte(q[k], 0);
    chk("reload_hold_during", 64'(cpu_hold), 64'(1));
    chk("reload_done_during", 64'(done), 64'(0));
    send_byte(q[4], 0);
    send_byte(q[5], 0);
    send_byte(q[6], 0);
    chk("reload_we_latency", 64'(bus.imem_we), 64'(1));
    chk("reload_waddr", 64'(bus.imem_waddr), 64'(0));
    chk("reload_wdata", 64'(bus.imem_wdata), 64'h00000013);
    send_byte(q[7], 0);
    chk("reload_we_single", 64'(bus.imem_we), 64'(0));
    chk("reload_done_latency", 64'(done), 64'(1));
    chk("reload_hold_latency", 64'(cpu_hold), 64'(0));
    repeat (2) @(negedge clk);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1);
    check_writes("reload");

    // Reset in the middle of a frame, then a full frame must load from address 0.
    q = '{8'hA5, 8'h02, 8'h00, 8'hB7, 8'h00};
    send_q(q, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    chk("midreset_nowrite", 64'(obs_a.size()), 64'(0));
    rst_n = 1'b1;
    obs_a.delete(); obs_d.delete();
    model_reset();
    q.delete();
    for (int k = 0; k < 12; k++) q.push_back(GOOD[8*(11-k) +: 8]);
    model_run(q);
    send_q(q, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 2);
    check_writes("after_reset");

    // Largest legal frame: N = 2^ADDR_W, last write lands on the top address.
    q.delete();
    q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h01);
    sum = 0;
    for (int k = 0; k < 4 * (1 << AW); k++) begin
      b = 8'($urandom_range(0, 255));
      sum += int'(b);
      q.push_back(b);
    end
    q.push_back(8'(sum));
    model_run(q);
    send_q(q, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_status("maxn", 1'b1, 1'b0, 1'b0, 1 << AW);
    if (obs_a.size() > 0) chk("maxn_last_addr", 64'(obs_a[obs_a.size()-1]), 64'hFF);
    check_writes("maxn");

    // Random frames with garbage, SYNC-valued data, bad counts and bad checksums.
    for (int f = 0; f < 40; f++) begin
      q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      q.push_back(8'hA5);
      if ($urandom_range(0, 9) == 0) begin
        n = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(257, 400));
        q.push_back(8'(n)); q.push_back(8'(n >> 8));
      end else begin
        n = int'($urandom_range(1, 5));
        q.push_back(8'(n)); q.push_back(8'h00);
        sum = 0;
        for (int k = 0; k < 4 * n; k++) begin
          b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
          sum += int'(b);
          q.push_back(b);
        end
        b = 8'(sum);
        if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
        q.push_back(b);
      end
      model_run(q);
      send_q(q, 2, 1'b1);
      repeat (3) @(negedge clk);
      check_status($sformatf("rnd%0d", f), m_done, m_err, m_hold, m_words);
      check_writes($sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: receives a framed byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words and writes them through the write port of the instruction memory.
- Holds the CPU in reset until a frame has loaded and its checksum has passed.
- Sits between the host byte link and the imem write port. The CPU fetch side is unaffected.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory (capacity 2^ADDR_W words).
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready
- imem_we  output  1  one-cycle instruction-memory write strobe
- imem_waddr  output  ADDR_W  word address of the write
- imem_wdata  output  32  instruction word to write
- cpu_hold  output  1  keeps the CPU in reset while 1
- done  output  1  frame loaded and checksum OK
- err  output  1  frame rejected
- words_loaded  output  ADDR_W+1  words written in the current or last frame

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low. While rst_n=0 and on release, outputs are:
  - rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0
  - cpu_hold=1, done=0, err=0, words_loaded=0
  - state=IDLE
- rx_ready rises the first clock edge after reset release, then stays 1 in every state. One byte is consumed per accepted transfer. Cycles with rx_valid=0 are ignored.
- Frame format:
  - SYNC
  - word count N as two bytes, low byte first
  - N words, 4 bytes each, least-significant byte first
  - checksum byte = sum mod 256 of all 4N payload bytes (header bytes excluded)
- IDLE: bytes other than SYNC are discarded. SYNC leads to LEN0 and also:
  - clears done and err
  - sets cpu_hold=1
  - resets the byte counter, word address and words_loaded to 0
  - resets the checksum accumulator to 0
- LEN0: latch the low count byte, go to LEN1.
- LEN1: latch the high count byte.
  - If N==0 or N>2^ADDR_W: go to ERR.
  - Otherwise go to DATA.
- DATA: shift bytes into a 32-bit assembly register, least-significant byte first, and add each byte to the checksum.
  - The 4th byte of a word completes it. On the next cycle: imem_we=1 for exactly one cycle, imem_waddr=current address, imem_wdata=assembled word.
  - The address and words_loaded then increment.
  - After word N: go to CHK.
- CHK: compare the received byte with the accumulated checksum.
  - Equal: go to DONE; done=1, cpu_hold=0.
  - Not equal: go to ERR.
- DONE: cpu_hold=0 and done=1 hold.
  - A SYNC byte starts a reload, with the same effects as SYNC in IDLE.
  - Other bytes are discarded.
- ERR: err=1 and cpu_hold=1 hold.
  - A SYNC byte restarts the frame, with the same effects as SYNC in IDLE.
  - Other bytes are discarded.
- Words already written before an error stay in memory. The CPU is not released.
- imem_waddr never wraps within a frame, because the N limit guarantees it. The final write goes to address N-1.
- imem_we is never asserted outside DATA-derived write cycles. At most one write occurs per 4 accepted bytes.
- SYNC bytes inside LEN, DATA or CHK are treated as data; there is no resync mid-frame.
- Reset mid-frame: the async reset aborts the frame immediately with all outputs at their reset values. Any write strobe in flight is dropped. The next frame loads from address 0.
- Latency:
  - Last byte of a word accepted to imem_we: 1 cycle.
  - Checksum byte accepted to done/cpu_hold update: 1 cycle.

Test Plan:
- Good frame, ADDR_W=8: bytes A5 02 00 B7 00 00 80 93 80 F0 FF 39 -> writes addr0=32'h800000b7 and addr1=32'hfff08093, one strobe each; then done=1, cpu_hold=0, err=0, words_loaded=2.
- Same frame with checksum 38 -> both writes occur, then err=1, done=0, cpu_hold=1. Resending the correct frame afterwards gives done=1.
- Leading garbage 00 FF 13 before the good frame, and rx_valid low for 3 cycles between each byte -> result identical to the first scenario, with no extra writes.
- Count errors: A5 00 00 -> err=1 and no write. A5 01 01 (N=257) -> err=1 and no write.
- Reset mid-load: assert rst_n=0 after A5 02 00 B7 00 -> all outputs reset and rx_ready=0 during reset. A full frame afterwards writes from address 0.
- Reload from DONE: after a good frame, send A5 01 00 13 00 00 00 13 -> cpu_hold=1 during the load, then addr0=32'h00000013, done=1, cpu_hold=0, words_loaded=1.
